// File: rtl/pfa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshaking and status flags.
// One prefix group of PIPE_LEVELS levels per pipeline stage; the last group feeds the output register.
module pfa_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_LEVELS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int unsigned L    = $clog2(WIDTH);
  localparam int unsigned NSTG = (L + PIPE_LEVELS - 1) / PIPE_LEVELS;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             v0;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rbp;
  logic             rc0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0  <= 1'b0;
      ra  <= '0;
      rbp <= '0;
      rc0 <= 1'b0;
    end else if (adv) begin
      v0  <= in_valid;
      ra  <= a;
      rbp <= b ^ {WIDTH{sub}};
      rc0 <= sub | cin;
    end
  end

  // Prefix vectors are {P, G}; position 0 holds the carry-in, position i holds bit i-1,
  // so after the tree G[i] is the carry into bit i.
  logic                 vin [NSTG];
  logic [2*WIDTH-1:0]   gpi [NSTG];
  logic [2*WIDTH-1:0]   gpo [NSTG];
  logic [WIDTH:0]       pog [NSTG];

  assign vin[0] = v0;
  assign gpi[0] = {ra[WIDTH-2:0] ^ rbp[WIDTH-2:0], 1'b0,
                   ra[WIDTH-2:0] & rbp[WIDTH-2:0], rc0};
  assign pog[0] = {ra[WIDTH-1] & rbp[WIDTH-1], ra ^ rbp};

  for (genvar j = 0; j < NSTG; j++) begin : grp
    localparam int unsigned LO = j * PIPE_LEVELS;
    localparam int unsigned HI = (LO + PIPE_LEVELS < L) ? LO + PIPE_LEVELS : L;

    logic [WIDTH-1:0] gt, pt, gn, pn;

    always_comb begin
      gt = gpi[j][WIDTH-1:0];
      pt = gpi[j][2*WIDTH-1:WIDTH];
      gn = gt;
      pn = pt;
      for (int unsigned k = LO; k < HI; k++) begin
        gn = gt;
        pn = pt;
        for (int unsigned i = (32'd1 << k); i < WIDTH; i++) begin
          gn[i] = gt[i] | (pt[i] & gt[i - (32'd1 << k)]);
          pn[i] = pt[i] & pt[i - (32'd1 << k)];
        end
        gt = gn;
        pt = pn;
      end
      gpo[j] = {pt, gt};
    end

    if (j > 0) begin : stg
      logic               vr;
      logic [2*WIDTH-1:0] gpr;
      logic [WIDTH:0]     pgr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vr  <= 1'b0;
          gpr <= '0;
          pgr <= '0;
        end else if (adv) begin
          vr  <= vin[j-1];
          gpr <= gpo[j-1];
          pgr <= pog[j-1];
        end
      end

      assign vin[j] = vr;
      assign gpi[j] = gpr;
      assign pog[j] = pgr;
    end
  end

  logic [WIDTH-1:0] pf, cf, sn;
  logic             gmf, coutn, ovfn;

  assign pf    = pog[NSTG-1][WIDTH-1:0];
  assign gmf   = pog[NSTG-1][WIDTH];
  assign cf    = gpo[NSTG-1][WIDTH-1:0];
  assign sn    = pf ^ cf;
  assign coutn = gmf | (pf[WIDTH-1] & cf[WIDTH-1]);
  // Equal operand MSBs means p_msb=0, and then g_msb equals that shared MSB.
  assign ovfn  = !pf[WIDTH-1] && (sn[WIDTH-1] != gmf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= vin[NSTG-1];
      if (vin[NSTG-1]) begin
        s    <= sn;
        cout <= coutn;
        ovf  <= ovfn;
        zero <= (sn == '0);
      end
    end
  end
endmodule

// File: doc/pfa_pipe.md
Name: pfa_pipe

Overview:
- Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor; generalised successor to the fixed 32-bit combinational prefix adder.
- Adds configurable width and pipeline depth, add/sub mode, status flags, and valid/ready handshaking with backpressure.
- Sits in the datapath as a multi-cycle ALU arithmetic unit and accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 32: operand and sum width in bits. Legal values are ≥2; other values are not supported.
- PIPE_LEVELS, 2: prefix levels per pipeline stage. Legal range is 1..clog2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Used only when sub=0.
- sub  input  1  0: a+b+cin. 1: a-b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out of the MSB. When sub=1, cout=1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

Behaviour:
- Reset is asynchronous; reset values take effect immediately on assertion:
  - every stage valid bit = 0, every data register = 0;
  - out_valid=0, s=0, cout=0, ovf=0, zero=0.
- Structure, with L = clog2(WIDTH):
  - Stage 0 registers a, b' (b' = b^{WIDTH{sub}}) and c0 (c0 = sub ? 1 : cin), then forms bitwise g = a&b' and p = a^b'.
  - Prefix tree of L Kogge-Stone levels: level k combines span 2^k, and the carry-in is folded in as the generate at position -1.
  - A register boundary follows every PIPE_LEVELS levels; the last group may be shorter.
  - Final stage computes s = p ^ {carries[WIDTH-2:0], c0}, plus cout, ovf and zero, into the output register.
- Latency: 1 + ceil(L / PIPE_LEVELS) cycles from an accepted beat to out_valid. WIDTH=32 with PIPE_LEVELS=2 gives 4 cycles.
- Throughput: 1 beat/cycle when out_ready is held high.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, which is combinational from out_valid and out_ready.
  - A beat is accepted on a rising edge when in_valid && in_ready.
  - When adv=1, every stage shifts one place, including bubbles; stage-0 valid loads in_valid.
  - When adv=0, all stages hold, and s/cout/ovf/zero stay stable while out_valid=1.
  - No bubble collapsing.
- Flags:
  - ovf = (a_msb == b'_msb) && (s_msb != a_msb).
  - zero is computed on the registered s.
  - Flags are meaningful only while out_valid=1 and hold their last values otherwise.
- Boundary cases:
  - Full pipeline with out_ready=0: in_ready=0, nothing is lost or duplicated.
  - Simultaneous output pop and input accept in the same cycle: both occur, with no stall cycle.
  - Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately. The first accepted beat after rst deasserts appears after the full latency.
  - Carry wrap-around: all-ones plus 1 yields s=0, cout=1, zero=1.
- The result must equal the reference arithmetic model {cout,s} = a + b' + c0 for every WIDTH and PIPE_LEVELS combination.

Test Plan:
- Add, WIDTH=32, PIPE_LEVELS=2, out_ready=1:
  - a=0x00FF00FF, b=0xFF00FF00, cin=0 -> after 4 cycles: s=0xFFFFFFFF, cout=0, ovf=0, zero=0.
  - Next cycle a=0xF3FF00FF, b=0x0C00FF00, cin=1 -> one cycle later: s=0x00000000, cout=1, zero=1, ovf=0.
- Signed overflow and subtract:
  - a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, ovf=1, cout=0.
  - a=5, b=7, sub=1, cin=1 -> s=0xFFFFFFFE, cout=0, ovf=0 (cin ignored).
- Backpressure: stream 8 back-to-back beats and drop out_ready for 3 cycles once out_valid rises:
  - in_ready=0 during the stall;
  - s is held stable;
  - all 8 results arrive in order, with no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle while 3 beats are in flight:
  - out_valid=0 immediately;
  - no stale beat emerges afterwards;
  - a new beat appears exactly 4 cycles after acceptance.
- Parametric: WIDTH=8 with PIPE_LEVELS=1 (latency 4) and PIPE_LEVELS=3 (latency 2), 1000 random beats each, with a random sub/cin mix and random out_ready:
  - every result matches the reference model;
  - 0xFF + 0x01 -> s=0x00, cout=1, zero=1.
